// File: rtl/xmit_frame_gen.sv
// Burst frame generator: marker/fill bytes with gaps, priority and abort.
// Define FRAME_GEN_SEQ_EN for sequence payload instead of FILL_BYTE.
module xmit_frame_gen #(
  parameter int          LEN_W     = 24,
  parameter int          CNT_W     = 16,
  parameter int          GAP_W     = 8,
  parameter int          MARK_LEN  = 4,
  parameter logic [7:0]  MARK_BYTE = 8'h33,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [1:0]       cfg_pri_mode,
  output logic [7:0]       f_data_in,
  output logic [LEN_W-1:0] f_ctrl_in,
  output logic             f_rec_data_valid,
  output logic             f_rec_frame_valid,
  output logic             f_hi_priority,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } state_t;

  localparam logic [LEN_W:0] MK = (LEN_W+1)'(MARK_LEN);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] j_q, j_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [7:0]       data_q, data_d;
  logic [LEN_W-1:0] ctrl_q, ctrl_d;
  logic             dv_q, dv_d;
  logic             fv_q, fv_d;
  logic             prio_q, prio_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // a_* are the values governing this cycle: the fresh cfg on the
  // start cycle so byte 0 leaves immediately, else the latched ones.
  logic             run;
  logic             first;
  logic [LEN_W-1:0] a_len;
  logic [CNT_W-1:0] a_cnt;
  logic [GAP_W-1:0] a_gap;
  logic [1:0]       a_mode;
  logic [LEN_W-1:0] a_j;
  logic [CNT_W-1:0] a_frames;
  logic             is_mark;
  logic             a_prio;
  logic [7:0]       payload;

  always_comb begin
    first    = (state_q == IDLE);
    a_len    = first ? cfg_len      : len_q;
    a_cnt    = first ? cfg_count    : cnt_q;
    a_gap    = first ? cfg_gap      : gap_q;
    a_mode   = first ? cfg_pri_mode : mode_q;
    a_j      = first ? '0           : j_q;
    a_frames = first ? '0           : frames_q;
    is_mark  = ({1'b0, a_j} < MK) ||
               ({1'b0, a_j} + MK >= {1'b0, a_len});
    a_prio   = (a_mode == 2'd1) ||
               ((a_mode == 2'd2) && !a_frames[0]);
`ifdef FRAME_GEN_SEQ_EN
    payload  = a_j[7:0] ^ a_frames[7:0];
`else
    payload  = FILL_BYTE;
`endif
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    j_d      = j_q;
    frames_d = frames_q;
    gcnt_d   = gcnt_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    prio_d   = prio_q;
    dv_d     = 1'b0;
    fv_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    run      = 1'b0;
    if (abort) begin
      state_d = IDLE;
      done_d  = busy_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_len == '0) begin
              err_d = 1'b1;
            end else begin
              len_d    = cfg_len;
              cnt_d    = cfg_count;
              gap_d    = cfg_gap;
              mode_d   = cfg_pri_mode;
              frames_d = '0;
              j_d      = '0;
              state_d  = FRAME;
              run      = 1'b1;
            end
          end
        end
        FRAME: run = 1'b1;
        GAP: begin
          if (gcnt_q <= GAP_W'(1)) state_d = FRAME;
          else gcnt_d = gcnt_q - GAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
      if (run && out_ready) begin
        dv_d   = 1'b1;
        fv_d   = (a_j == '0);
        data_d = is_mark ? MARK_BYTE : payload;
        prio_d = a_prio;
        if (a_j == '0) ctrl_d = a_len;
        if (a_j == a_len - LEN_W'(1)) begin
          frames_d = a_frames + CNT_W'(1);
          j_d      = '0;
          if ((a_cnt != '0) && (frames_d == a_cnt)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (a_gap != '0) begin
            state_d = GAP;
            gcnt_d  = a_gap;
          end else begin
            state_d = FRAME;
          end
        end else begin
          j_d = a_j + LEN_W'(1);
        end
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      mode_q   <= '0;
      j_q      <= '0;
      frames_q <= '0;
      gcnt_q   <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      dv_q     <= 1'b0;
      fv_q     <= 1'b0;
      prio_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      j_q      <= j_d;
      frames_q <= frames_d;
      gcnt_q   <= gcnt_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      dv_q     <= dv_d;
      fv_q     <= fv_d;
      prio_q   <= prio_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign f_data_in         = data_q;
  assign f_ctrl_in         = ctrl_q;
  assign f_rec_data_valid  = dv_q;
  assign f_rec_frame_valid = fv_q;
  assign f_hi_priority     = prio_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign cfg_err           = err_q;
  assign frames_sent       = frames_q;

endmodule
